// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Prioritised edge-latched interrupt controller with mask,
//               IntAck/DrData vector handshake and spurious-ack handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller #(
  parameter int          NUM_SRC  = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               ie,
  input  logic               inta,
  input  logic               dr_data,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_din,
  output logic               int_req,
  output logic [NUM_SRC-1:0] ack_out,
  output logic [31:0]        vec_out,
  output logic               vec_oe,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic               busy
);

  localparam int ID_W = $clog2(NUM_SRC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_VEC  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [NUM_SRC-1:0] r_irq_q;
  logic               r_arm;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [ID_W-1:0]    r_id_q;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_elig;
  logic [ID_W-1:0]    w_win;

  // r_arm stays low for the first cycle after reset so lines already high
  // while in reset are absorbed into r_irq_q instead of looking like edges.
  assign w_edge = irq & ~r_irq_q & {NUM_SRC{r_arm}};
  assign w_elig = r_pending & ~r_mask;

  // Lowest index wins; NUM_SRC encodes "nothing eligible".
  always_comb begin
    w_win = ID_W'(NUM_SRC);
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_q <= '0;
      r_arm   <= 1'b0;
      r_mask  <= '1;
    end else begin
      r_irq_q <= irq;
      r_arm   <= 1'b1;
      if (mask_wr) r_mask <= mask_din;
    end
  end

  // Set has priority over the acknowledge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~ack_out) | w_edge;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_q <= '0;
    end else if (inta) begin
      if (r_state == S_IDLE)     r_id_q <= ID_W'(NUM_SRC);
      else if (r_state == S_REQ) r_id_q <= w_win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (inta)                 w_state_nxt = S_ACK;
        else if ((|w_elig) && ie) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (inta)          w_state_nxt = S_ACK;
        else if (~|w_elig) w_state_nxt = S_IDLE;
      end
      S_ACK:   w_state_nxt = S_VEC;
      S_VEC: begin
        if (dr_data) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    int_req = (r_state == S_REQ);
    busy    = (r_state != S_IDLE);
    vec_oe  = (r_state == S_VEC) && dr_data;
    vec_out = vec_oe ? (VEC_BASE + 32'(r_id_q)) : 32'd0;
    ack_out = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_out[i] = (r_state == S_ACK) && (r_id_q == ID_W'(i));
    end
  end

  assign pending = r_pending;
  assign mask    = r_mask;

endmodule

`default_nettype wire
